// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between an instruction-fetch requester (m0) and a
// data requester (m1): same-cycle grant, one-cycle-latency response routing.
module ram_arbiter #(
   parameter int unsigned RR_MODE = 1
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        m0_req,
   output logic        m0_gnt,
   input  logic [31:0] m0_addr,
   input  logic        m0_we,
   input  logic [3:0]  m0_be,
   input  logic [31:0] m0_wdata,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,

   input  logic        m1_req,
   output logic        m1_gnt,
   input  logic [31:0] m1_addr,
   input  logic        m1_we,
   input  logic [3:0]  m1_be,
   input  logic [31:0] m1_wdata,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,

   output logic        ram_req,
   output logic [31:0] ram_addr,
   output logic        ram_we,
   output logic [3:0]  ram_be,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata
);

   logic fixed_prio;
   logic any_req;
   logic sel1;
   logic last_gnt;
   logic rsp_valid;
   logic rsp_owner;

   assign fixed_prio = (RR_MODE == 0);

   // Requests are masked while reset is asserted so nothing reaches the RAM.
   assign any_req = rst_n & (m0_req | m1_req);

   // m1 wins when alone, under fixed priority, or when m0 won most recently.
   assign sel1 = rst_n & m1_req & (~m0_req | fixed_prio | ~last_gnt);

   assign m0_gnt = any_req & ~sel1;
   assign m1_gnt = sel1;

   assign ram_req   = any_req;
   assign ram_addr  = sel1 ? m1_addr  : m0_addr;
   assign ram_be    = sel1 ? m1_be    : m0_be;
   assign ram_wdata = sel1 ? m1_wdata : m0_wdata;
   assign ram_we    = rst_n & (sel1 ? m1_we : m0_we);

   // last_gnt resets to 1 so m0 takes the first contention.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_gnt  <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_owner <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignment so every register
         // samples pre-edge values regardless of statement order.
         rsp_valid <= any_req;
         if (any_req) begin
            last_gnt  <= sel1;
            rsp_owner <= sel1;
         end
      end
   end

   assign m0_rvalid = rsp_valid & ~rsp_owner;
   assign m1_rvalid = rsp_valid &  rsp_owner;
   assign m0_rdata  = m0_rvalid ? ram_rdata : 32'h0;
   assign m1_rdata  = m1_rvalid ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a round-robin and a fixed-priority instance share the
// same requester stimulus, each with its own RAM and behavioural model.
module tb_ram_arbiter;

   typedef struct packed {
      logic        req;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } req_t;

   localparam req_t IDLE = '0;

   logic clk;
   logic rst_n;
   logic mem_loaded;
   req_t in0, in1;

   // index 0: RR_MODE=1 instance, index 1: RR_MODE=0 instance
   logic        g0 [2];
   logic        g1 [2];
   logic        rv0 [2];
   logic        rv1 [2];
   logic [31:0] rd0 [2];
   logic [31:0] rd1 [2];
   logic        rq [2];
   logic [31:0] raddr [2];
   logic        rwe [2];
   logic [3:0]  rbe [2];
   logic [31:0] rwd [2];
   logic [31:0] rrd [2];

   logic [31:0] ram [2][16];

   // model state per instance
   int          last_w [2];
   logic        pv [2];
   int          po [2];
   logic [31:0] pdat [2];
   logic [31:0] mmem [2][16];

   int n_cmp;
   int n_bad;

   ram_arbiter #(.RR_MODE(1)) dut_rr (
      .clk(clk), .rst_n(rst_n),
      .m0_req(in0.req), .m0_gnt(g0[0]), .m0_addr(in0.addr), .m0_we(in0.we),
      .m0_be(in0.be), .m0_wdata(in0.wdata), .m0_rvalid(rv0[0]), .m0_rdata(rd0[0]),
      .m1_req(in1.req), .m1_gnt(g1[0]), .m1_addr(in1.addr), .m1_we(in1.we),
      .m1_be(in1.be), .m1_wdata(in1.wdata), .m1_rvalid(rv1[0]), .m1_rdata(rd1[0]),
      .ram_req(rq[0]), .ram_addr(raddr[0]), .ram_we(rwe[0]), .ram_be(rbe[0]),
      .ram_wdata(rwd[0]), .ram_rdata(rrd[0])
   );

   ram_arbiter #(.RR_MODE(0)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .m0_req(in0.req), .m0_gnt(g0[1]), .m0_addr(in0.addr), .m0_we(in0.we),
      .m0_be(in0.be), .m0_wdata(in0.wdata), .m0_rvalid(rv0[1]), .m0_rdata(rd0[1]),
      .m1_req(in1.req), .m1_gnt(g1[1]), .m1_addr(in1.addr), .m1_we(in1.we),
      .m1_be(in1.be), .m1_wdata(in1.wdata), .m1_rvalid(rv1[1]), .m1_rdata(rd1[1]),
      .ram_req(rq[1]), .ram_addr(raddr[1]), .ram_we(rwe[1]), .ram_be(rbe[1]),
      .ram_wdata(rwd[1]), .ram_rdata(rrd[1])
   );

   function automatic logic [31:0] init_word(input int i);
      if (i == 4) return 32'hDEADBEEF;
      if (i == 8) return 32'h11223344;
      return 32'hC0DE0000 + 32'(i) * 32'h00010101;
   endfunction

   function automatic req_t mk(input logic r, input logic [31:0] a, input logic w,
                               input logic [3:0] be, input logic [31:0] wd);
      req_t x;
      x.req = r; x.addr = a; x.we = w; x.be = be; x.wdata = wd;
      return x;
   endfunction

   function automatic req_t rand_req();
      return mk($urandom_range(0, 3) != 0, 32'($urandom_range(0, 15)) << 2,
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered RAM with read-before-write, loaded once at start-up.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!mem_loaded) begin
            for (int i = 0; i < 16; i++) ram[d][i] <= init_word(i);
         end else if (rq[d]) begin
            rrd[d] <= ram[d][raddr[d][5:2]];
            if (rwe[d])
               for (int b = 0; b < 4; b++)
                  if (rbe[d][b]) ram[d][raddr[d][5:2]][8*b +: 8] <= rwd[d][8*b +: 8];
         end
      end
   end

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         last_w[d] = 1;
         pv[d]     = 1'b0;
         po[d]     = 0;
         pdat[d]   = '0;
      end
   endtask

   // One clock cycle: apply requests after the falling edge, check every
   // output of both instances against the model, then advance the model.
   task automatic run_cycle(input req_t a, input req_t b, output int w_rr);
      int          w;
      req_t        win;
      logic        e_rv0, e_rv1;
      int          idx;
      w_rr = -1;
      @(negedge clk);
      in0 = a;
      in1 = b;
      #1;
      for (int d = 0; d < 2; d++) begin
         if (!rst_n || (!a.req && !b.req)) w = -1;
         else if (a.req && b.req)          w = (d == 0) ? 1 - last_w[d] : 1;
         else                              w = a.req ? 0 : 1;
         win = (w == 1) ? b : a;
         e_rv0 = pv[d] && (po[d] == 0);
         e_rv1 = pv[d] && (po[d] == 1);

         n_cmp++; if (g0[d] !== (w == 0)) begin n_bad++; $display("FAIL d%0d m0_gnt: got %b want %b", d, g0[d], w == 0); end
         n_cmp++; if (g1[d] !== (w == 1)) begin n_bad++; $display("FAIL d%0d m1_gnt: got %b want %b", d, g1[d], w == 1); end
         n_cmp++; if (rq[d] !== (w >= 0)) begin n_bad++; $display("FAIL d%0d ram_req: got %b want %b", d, rq[d], w >= 0); end
         n_cmp++; if (raddr[d] !== win.addr) begin n_bad++; $display("FAIL d%0d ram_addr: got %h want %h", d, raddr[d], win.addr); end
         n_cmp++; if (rbe[d] !== win.be) begin n_bad++; $display("FAIL d%0d ram_be: got %h want %h", d, rbe[d], win.be); end
         n_cmp++; if (rwd[d] !== win.wdata) begin n_bad++; $display("FAIL d%0d ram_wdata: got %h want %h", d, rwd[d], win.wdata); end
         n_cmp++; if (rwe[d] !== (rst_n & win.we)) begin n_bad++; $display("FAIL d%0d ram_we: got %b want %b", d, rwe[d], rst_n & win.we); end
         n_cmp++; if (rv0[d] !== e_rv0) begin n_bad++; $display("FAIL d%0d m0_rvalid: got %b want %b", d, rv0[d], e_rv0); end
         n_cmp++; if (rv1[d] !== e_rv1) begin n_bad++; $display("FAIL d%0d m1_rvalid: got %b want %b", d, rv1[d], e_rv1); end
         n_cmp++; if (rd0[d] !== (e_rv0 ? pdat[d] : 32'h0)) begin n_bad++; $display("FAIL d%0d m0_rdata: got %h want %h", d, rd0[d], e_rv0 ? pdat[d] : 32'h0); end
         n_cmp++; if (rd1[d] !== (e_rv1 ? pdat[d] : 32'h0)) begin n_bad++; $display("FAIL d%0d m1_rdata: got %h want %h", d, rd1[d], e_rv1 ? pdat[d] : 32'h0); end

         pv[d] = (w >= 0);
         if (w >= 0) begin
            idx       = int'(win.addr[5:2]);
            pdat[d]   = mmem[d][idx];
            po[d]     = w;
            last_w[d] = w;
            if (win.we)
               for (int k = 0; k < 4; k++)
                  if (win.be[k]) mmem[d][idx][8*k +: 8] = win.wdata[8*k +: 8];
         end
         if (d == 0) w_rr = w;
      end
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      mem_loaded = 1'b0;
      in0 = mk(1'b1, 32'h44, 1'b1, 4'hF, 32'h5);
      in1 = mk(1'b1, 32'h48, 1'b1, 4'h3, 32'h6);
      #1;
      for (int d = 0; d < 2; d++) begin
         n_cmp++; if (g0[d] !== 1'b0 || g1[d] !== 1'b0) begin n_bad++; $display("FAIL d%0d reset_gnt: got %b%b want 00", d, g0[d], g1[d]); end
         n_cmp++; if (rq[d] !== 1'b0) begin n_bad++; $display("FAIL d%0d reset_ram_req: got %b want 0", d, rq[d]); end
         n_cmp++; if (rwe[d] !== 1'b0) begin n_bad++; $display("FAIL d%0d reset_ram_we: got %b want 0", d, rwe[d]); end
         n_cmp++; if (raddr[d] !== 32'h44 || rbe[d] !== 4'hF || rwd[d] !== 32'h5) begin n_bad++; $display("FAIL d%0d reset_payload: got %h/%h/%h want 44/f/5", d, raddr[d], rbe[d], rwd[d]); end
         n_cmp++; if (rv0[d] !== 1'b0 || rv1[d] !== 1'b0 || rd0[d] !== 32'h0 || rd1[d] !== 32'h0) begin n_bad++; $display("FAIL d%0d reset_rsp: got %b%b %h %h want 00 0 0", d, rv0[d], rv1[d], rd0[d], rd1[d]); end
      end
      @(posedge clk);
      @(negedge clk);
      mem_loaded = 1'b1;
      in0 = IDLE;
      in1 = IDLE;
      rst_n = 1'b1;
      model_reset();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 16; i++) mmem[d][i] = init_word(i);
   endtask

   task automatic test_contention();
      int w;
      for (int k = 0; k < 4; k++) begin
         run_cycle(mk(1'b1, 32'h10, 1'b0, 4'h0, 32'h0), mk(1'b1, 32'h24, 1'b0, 4'h0, 32'h0), w);
         n_cmp++; if (g0[0] !== ((k % 2) == 0)) begin n_bad++; $display("FAIL rr_seq%0d: got m0_gnt=%b want %b", k, g0[0], (k % 2) == 0); end
         n_cmp++; if (g1[1] !== 1'b1) begin n_bad++; $display("FAIL fp_seq%0d: got m1_gnt=%b want 1", k, g1[1]); end
      end
      run_cycle(IDLE, IDLE, w);
      n_cmp++; if (rv1[0] !== 1'b1 || rd1[0] !== init_word(9)) begin n_bad++; $display("FAIL rr_last_rsp: got %b %h want 1 %h", rv1[0], rd1[0], init_word(9)); end
   endtask

   task automatic test_single_read();
      int w;
      run_cycle(mk(1'b1, 32'h10, 1'b0, 4'h0, 32'h0), IDLE, w);
      n_cmp++; if (g0[0] !== 1'b1) begin n_bad++; $display("FAIL single_gnt: got %b want 1", g0[0]); end
      run_cycle(IDLE, IDLE, w);
      n_cmp++; if (rv0[0] !== 1'b1 || rd0[0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_rsp: got %b %h want 1 deadbeef", rv0[0], rd0[0]); end
      n_cmp++; if (rv1[0] !== 1'b0) begin n_bad++; $display("FAIL single_m1_quiet: got %b want 0", rv1[0]); end
   endtask

   task automatic test_fixed_priority();
      int w;
      for (int k = 0; k < 3; k++) begin
         run_cycle(mk(1'b1, 32'h0C, 1'b0, 4'h0, 32'h0), mk(1'b1, 32'h14, 1'b0, 4'h0, 32'h0), w);
         n_cmp++; if (g1[1] !== 1'b1 || g0[1] !== 1'b0) begin n_bad++; $display("FAIL fp_hold%0d: got m0/m1 gnt %b%b want 01", k, g0[1], g1[1]); end
      end
      run_cycle(mk(1'b1, 32'h0C, 1'b0, 4'h0, 32'h0), IDLE, w);
      n_cmp++; if (g0[1] !== 1'b1) begin n_bad++; $display("FAIL fp_release: got m0_gnt=%b want 1", g0[1]); end
      run_cycle(IDLE, IDLE, w);
   endtask

   task automatic test_byte_write();
      int w;
      run_cycle(IDLE, mk(1'b1, 32'h20, 1'b1, 4'b0010, 32'h0000AB00), w);
      run_cycle(IDLE, mk(1'b1, 32'h20, 1'b0, 4'h0, 32'h0), w);
      n_cmp++; if (rv1[0] !== 1'b1 || rd1[0] !== 32'h11223344) begin n_bad++; $display("FAIL bw_write_rsp: got %b %h want 1 11223344", rv1[0], rd1[0]); end
      run_cycle(IDLE, IDLE, w);
      n_cmp++; if (rv1[0] !== 1'b1 || rd1[0] !== 32'h1122AB44) begin n_bad++; $display("FAIL bw_read_rsp: got %b %h want 1 1122ab44", rv1[0], rd1[0]); end
   endtask

   task automatic test_reset_mid();
      int w;
      run_cycle(mk(1'b1, 32'h10, 1'b0, 4'h0, 32'h0), IDLE, w);
      @(posedge clk);
      #1;
      n_cmp++; if (rv0[0] !== 1'b1) begin n_bad++; $display("FAIL rm_pending: got %b want 1", rv0[0]); end
      in0.req = 1'b1;
      in1.req = 1'b1;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_cmp++; if (rv0[0] !== 1'b0 || rv0[1] !== 1'b0) begin n_bad++; $display("FAIL rm_drop: got %b%b want 00", rv0[0], rv0[1]); end
      n_cmp++; if (g0[0] !== 1'b0 || g1[0] !== 1'b0 || rq[0] !== 1'b0) begin n_bad++; $display("FAIL rm_mask: got gnt %b%b req %b want 000", g0[0], g1[0], rq[0]); end
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         n_cmp++; if (rv0[0] !== 1'b0 || rv1[0] !== 1'b0) begin n_bad++; $display("FAIL rm_hold%0d: got %b%b want 00", k, rv0[0], rv1[0]); end
      end
      in0 = IDLE;
      in1 = IDLE;
      rst_n = 1'b1;
      run_cycle(mk(1'b1, 32'h18, 1'b0, 4'h0, 32'h0), mk(1'b1, 32'h1C, 1'b0, 4'h0, 32'h0), w);
      n_cmp++; if (g0[0] !== 1'b1 || rq[0] !== 1'b1) begin n_bad++; $display("FAIL rm_first_contention: got gnt0 %b req %b want 1 1", g0[0], rq[0]); end
      run_cycle(IDLE, IDLE, w);
   endtask

   task automatic test_random();
      req_t a, b;
      int   w;
      a = IDLE;
      b = IDLE;
      for (int k = 0; k < 400; k++) begin
         // a requester keeps its request and payload until the RR instance grants it
         if (!(a.req && w != 0) || k == 0) a = rand_req();
         if (!(b.req && w != 1) || k == 0) b = rand_req();
         run_cycle(a, b, w);
      end
      run_cycle(IDLE, IDLE, w);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_contention();
      test_single_read();
      test_fixed_priority();
      test_byte_write();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
